// File: rtl/gemm_sched_pkg.sv
// Shared types and helpers for the GeMM job scheduler.
// The job struct widths match the scheduler's default AddrWidth/IdWidth.
package gemm_sched_pkg;

   localparam int unsigned AddrW         = 16;
   localparam int unsigned IdW           = 4;
   localparam int unsigned CycleCntWidth = 32;

   typedef struct packed {
      logic [AddrW-1:0] m;
      logic [AddrW-1:0] k;
      logic [AddrW-1:0] n;
      logic [IdW-1:0]   id;
   } gemm_job_t;

   typedef enum logic [1:0] {
      SchedIdle   = 2'd0,
      SchedStart  = 2'd1,
      SchedRun    = 2'd2,
      SchedReport = 2'd3
   } sched_state_e;

   function automatic logic job_has_zero(input gemm_job_t j);
      return (j.m == {AddrW{1'b0}}) || (j.k == {AddrW{1'b0}}) || (j.n == {AddrW{1'b0}});
   endfunction

   // Saturating increment: the counter sticks at all-ones.
   function automatic logic [CycleCntWidth-1:0] sat_inc(input logic [CycleCntWidth-1:0] v);
      if (&v) return v;
      else    return v + {{(CycleCntWidth-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/gemm_job_fifo.sv
// Job FIFO for the GeMM scheduler; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module gemm_job_fifo
   import gemm_sched_pkg::*;
#(
   parameter type         T     = gemm_job_t,
   parameter int unsigned Depth = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned IdxW = $clog2(Depth);
   localparam int unsigned PtrW = IdxW + 1;
   localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

   T                mem_q [Depth];
   logic [PtrW-1:0] wr_q, rd_q;
   logic            push_ok_s, pop_ok_s;

   assign full_o    = (wr_q[IdxW-1:0] == rd_q[IdxW-1:0]) && (wr_q[IdxW] != rd_q[IdxW]);
   assign empty_o   = (wr_q == rd_q);
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;
   assign data_o    = mem_q[rd_q[IdxW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= {PtrW{1'b0}};
         rd_q <= {PtrW{1'b0}};
      end else begin
         if (push_ok_s) wr_q <= wr_q + PtrOne;
         if (pop_ok_s)  rd_q <= rd_q + PtrOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok_s) mem_q[wr_q[IdxW-1:0]] <= data_i;
   end

endmodule

// File: rtl/gemm_job_scheduler.sv
// GeMM job queue and sequencer: Idle -> Start -> Run -> Report, one job in flight.
// GEMM_SCHED_PERF_EN builds the saturating Start-to-done cycle counter.
module gemm_job_scheduler
   import gemm_sched_pkg::*;
#(
   parameter int unsigned AddrWidth = AddrW,
   parameter int unsigned IdWidth   = IdW,
   parameter int unsigned Depth     = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     job_valid_i,
   output logic                     job_ready_o,
   input  logic [AddrWidth-1:0]     job_m_i,
   input  logic [AddrWidth-1:0]     job_k_i,
   input  logic [AddrWidth-1:0]     job_n_i,
   input  logic [IdWidth-1:0]       job_id_i,
   output logic                     ctrl_start_o,
   output logic [AddrWidth-1:0]     ctrl_m_size_o,
   output logic [AddrWidth-1:0]     ctrl_k_size_o,
   output logic [AddrWidth-1:0]     ctrl_n_size_o,
   input  logic                     ctrl_done_i,
   output logic                     cmpl_valid_o,
   input  logic                     cmpl_ready_i,
   output logic [IdWidth-1:0]       cmpl_id_o,
   output logic                     cmpl_err_o,
   output logic [CycleCntWidth-1:0] cmpl_cycles_o,
   output logic                     busy_o
);

   sched_state_e state_q, state_d;
   gemm_job_t    push_job_s, head_s;
   logic         fifo_full_s, fifo_empty_s, pop_s, zero_s;
   logic         start_q, valid_q, err_q;
   logic [AddrWidth-1:0] m_q, k_q, n_q;
   logic [IdWidth-1:0]   id_q;

   assign push_job_s = '{m: job_m_i, k: job_k_i, n: job_n_i, id: job_id_i};
   assign pop_s      = (state_q == SchedIdle) && !fifo_empty_s;
   assign zero_s     = job_has_zero(head_s);

   gemm_job_fifo #(
      .T     (gemm_job_t),
      .Depth (Depth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (job_valid_i),
      .data_i  (push_job_s),
      .pop_i   (pop_s),
      .data_o  (head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         SchedIdle: begin
            if (pop_s) state_d = zero_s ? SchedReport : SchedStart;
            else       state_d = SchedIdle;
         end
         SchedStart:  state_d = SchedRun;
         SchedRun: begin
            if (ctrl_done_i) state_d = SchedReport;
            else             state_d = SchedRun;
         end
         SchedReport: begin
            if (cmpl_ready_i) state_d = SchedIdle;
            else              state_d = SchedReport;
         end
         default:     state_d = SchedIdle;
      endcase
   end

   // Start and valid are registered from the next state so they line up with the FSM.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= SchedIdle;
         start_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         id_q    <= {IdWidth{1'b0}};
         m_q     <= {AddrWidth{1'b0}};
         k_q     <= {AddrWidth{1'b0}};
         n_q     <= {AddrWidth{1'b0}};
      end else begin
         state_q <= state_d;
         start_q <= (state_d == SchedStart);
         valid_q <= (state_d == SchedReport);
         if (pop_s) begin
            m_q   <= head_s.m;
            k_q   <= head_s.k;
            n_q   <= head_s.n;
            id_q  <= head_s.id;
            err_q <= zero_s;
         end
      end
   end

`ifdef GEMM_SCHED_PERF_EN
   logic [CycleCntWidth-1:0] cnt_q, cycles_q;

   // The Start cycle counts as 1, so a job with done L cycles after Start reports L+1.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q    <= {CycleCntWidth{1'b0}};
         cycles_q <= {CycleCntWidth{1'b0}};
      end else begin
         if (pop_s)                                       cnt_q <= {CycleCntWidth{1'b0}};
         else if (state_q inside {SchedStart, SchedRun}) cnt_q <= sat_inc(cnt_q);
         if (pop_s && zero_s)                        cycles_q <= {CycleCntWidth{1'b0}};
         else if (state_q == SchedRun && ctrl_done_i) cycles_q <= sat_inc(cnt_q);
      end
   end

   assign cmpl_cycles_o = cycles_q;
`else
   assign cmpl_cycles_o = {CycleCntWidth{1'b0}};
`endif

   assign job_ready_o   = !fifo_full_s;
   assign ctrl_start_o  = start_q;
   assign ctrl_m_size_o = m_q;
   assign ctrl_k_size_o = k_q;
   assign ctrl_n_size_o = n_q;
   assign cmpl_valid_o  = valid_q;
   assign cmpl_id_o     = id_q;
   assign cmpl_err_o    = err_q;
   assign busy_o        = (state_q != SchedIdle) || !fifo_empty_s;

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// Scoreboard bench for gemm_job_scheduler; expected completions are queued on acceptance.
module tb_gemm_job_scheduler;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        job_valid_i;
   logic        job_ready_o;
   logic [15:0] job_m_i, job_k_i, job_n_i;
   logic [3:0]  job_id_i;
   logic        ctrl_start_o;
   logic [15:0] ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o;
   logic        ctrl_done_i;
   logic        cmpl_valid_o;
   logic        cmpl_ready_i;
   logic [3:0]  cmpl_id_o;
   logic        cmpl_err_o;
   logic [31:0] cmpl_cycles_o;
   logic        busy_o;

   typedef struct {
      logic [3:0]  id;
      logic        err;
      logic [31:0] cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   chk_cnt = 0;
   int   err_cnt = 0;
   int   done_lat = 10;
   int   cyc_cnt = 0;
   int   s_cyc = 0;
   bit   auto_done = 1'b0;
   logic auto_pulse = 1'b0;
   logic man_done = 1'b0;

   assign ctrl_done_i = auto_pulse | man_done;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   gemm_job_scheduler dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .job_valid_i   (job_valid_i),
      .job_ready_o   (job_ready_o),
      .job_m_i       (job_m_i),
      .job_k_i       (job_k_i),
      .job_n_i       (job_n_i),
      .job_id_i      (job_id_i),
      .ctrl_start_o  (ctrl_start_o),
      .ctrl_m_size_o (ctrl_m_size_o),
      .ctrl_k_size_o (ctrl_k_size_o),
      .ctrl_n_size_o (ctrl_n_size_o),
      .ctrl_done_i   (ctrl_done_i),
      .cmpl_valid_o  (cmpl_valid_o),
      .cmpl_ready_i  (cmpl_ready_i),
      .cmpl_id_o     (cmpl_id_o),
      .cmpl_err_o    (cmpl_err_o),
      .cmpl_cycles_o (cmpl_cycles_o),
      .busy_o        (busy_o)
   );

   function automatic logic [31:0] exp_cycles(input logic err, input int lat);
`ifdef GEMM_SCHED_PERF_EN
      return err ? 32'd0 : 32'(lat + 1);
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic offer(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n,
                        input logic [3:0] id);
      int   w = 0;
      logic z;
      job_valid_i = 1'b1;
      job_m_i = m; job_k_i = k; job_n_i = n; job_id_i = id;
      while (!job_ready_o && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) begin
         chk_cnt++; err_cnt++;
         $display("FAIL offer_timeout id=%0d ready=%b required 1", id, job_ready_o);
         job_valid_i = 1'b0;
         return;
      end
      z = (m == 16'd0) || (k == 16'd0) || (n == 16'd0);
      exp_q.push_back('{id: id, err: z, cyc: exp_cycles(z, done_lat)});
      tick();
      job_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int w = 0;
      while ((busy_o || exp_q.size() != 0) && w < 500) begin
         tick();
         w++;
      end
      chk_cnt++;
      if (w >= 500) begin
         err_cnt++;
         $display("FAIL drain_timeout busy=%b pending=%0d required 0/0", busy_o, exp_q.size());
      end
   endtask

   // Controller model: answers each start with done after done_lat cycles.
   initial begin
      forever begin
         tick();
         if (ctrl_start_o && auto_done) begin
            repeat (done_lat) @(posedge clk_i);
            #1 auto_pulse = 1'b1;
            tick();
            auto_pulse = 1'b0;
         end
      end
   end

   // Scoreboard: every completion handshake pops and compares the oldest expectation.
   always @(negedge clk_i) begin
      if (rst_ni && cmpl_valid_o && cmpl_ready_i) begin
         if (exp_q.size() == 0) begin
            chk_cnt++; err_cnt++;
            $display("FAIL unexpected_cmpl id=%0d with empty scoreboard", cmpl_id_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk_cnt += 3;
            if (cmpl_id_o !== mon_e.id) begin
               err_cnt++;
               $display("FAIL cmpl_id got %0d required %0d", cmpl_id_o, mon_e.id);
            end
            if (cmpl_err_o !== mon_e.err) begin
               err_cnt++;
               $display("FAIL cmpl_err id=%0d got %b required %b", mon_e.id, cmpl_err_o, mon_e.err);
            end
            if (cmpl_cycles_o !== mon_e.cyc) begin
               err_cnt++;
               $display("FAIL cmpl_cycles id=%0d got %0d required %0d", mon_e.id, cmpl_cycles_o, mon_e.cyc);
            end
         end
      end
   end

   task automatic test_reset();
      rst_ni = 1'b0; job_valid_i = 1'b0; cmpl_ready_i = 1'b1;
      job_m_i = 16'd0; job_k_i = 16'd0; job_n_i = 16'd0; job_id_i = 4'd0;
      tick(); tick();
      chk_cnt += 3;
      if ({ctrl_start_o, cmpl_valid_o, busy_o, job_ready_o} !== 4'b0001) begin
         err_cnt++;
         $display("FAIL reset_ctrl start/valid/busy/ready=%b required 0001",
                  {ctrl_start_o, cmpl_valid_o, busy_o, job_ready_o});
      end
      if ({ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o} !== 48'd0) begin
         err_cnt++;
         $display("FAIL reset_sizes got %0d/%0d/%0d required 0", ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o);
      end
      if ({cmpl_id_o, cmpl_err_o, cmpl_cycles_o} !== 37'd0) begin
         err_cnt++;
         $display("FAIL reset_cmpl id=%0d err=%b cyc=%0d required 0", cmpl_id_o, cmpl_err_o, cmpl_cycles_o);
      end
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int n = 0;
      int extra = 0;
      done_lat = 10; auto_done = 1'b1;
      offer(16'd2, 16'd3, 16'd4, 4'd5);
      chk_cnt += 2;
      if (ctrl_start_o !== 1'b0) begin
         err_cnt++; $display("FAIL single_early_start got %b required 0", ctrl_start_o);
      end
      tick();
      if (ctrl_start_o !== 1'b1 || busy_o !== 1'b1) begin
         err_cnt++; $display("FAIL single_start start=%b busy=%b required 1/1", ctrl_start_o, busy_o);
      end
      chk_cnt++;
      if ({ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o} !== {16'd2, 16'd3, 16'd4}) begin
         err_cnt++;
         $display("FAIL single_sizes got %0d/%0d/%0d required 2/3/4", ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o);
      end
      while (!cmpl_valid_o && n < 40) begin
         tick();
         n++;
         if (ctrl_start_o) extra++;
      end
      chk_cnt += 2;
      if (n !== done_lat + 1) begin
         err_cnt++; $display("FAIL single_latency got %0d cycles required %0d", n, done_lat + 1);
      end
      if (extra !== 0) begin
         err_cnt++; $display("FAIL single_start_width extra start cycles %0d required 0", extra);
      end
      wait_drain();
   endtask

   task automatic test_back_to_back();
      auto_done = 1'b0; done_lat = 3;
      offer(16'd1, 16'd1, 16'd1, 4'd9);
      tick();
      s_cyc = cyc_cnt;
      chk_cnt++;
      if (ctrl_start_o !== 1'b1) begin
         err_cnt++; $display("FAIL b2b_blocker_start got %b required 1", ctrl_start_o);
      end
      for (int i = 0; i < 4; i++) offer(16'(i + 1), 16'd2, 16'd3, 4'(i));
      chk_cnt += 2;
      if (job_ready_o !== 1'b0 || busy_o !== 1'b1) begin
         err_cnt++; $display("FAIL b2b_full ready=%b busy=%b required 0/1", job_ready_o, busy_o);
      end
      if ({ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o} !== {16'd1, 16'd1, 16'd1}) begin
         err_cnt++;
         $display("FAIL b2b_sizes_hold got %0d/%0d/%0d required 1/1/1", ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o);
      end
   endtask

   task automatic test_full_push_pop();
      int idle_bad = 0;
      auto_done = 1'b1;
      job_valid_i = 1'b1; job_m_i = 16'd1; job_k_i = 16'd1; job_n_i = 16'd1; job_id_i = 4'd14;
      man_done = 1'b1;
      exp_q[0].cyc = exp_cycles(1'b0, cyc_cnt - s_cyc);
      tick();
      man_done = 1'b0;
      chk_cnt += 2;
      if (job_ready_o !== 1'b0 || cmpl_valid_o !== 1'b1) begin
         err_cnt++; $display("FAIL fpp_report ready=%b valid=%b required 0/1", job_ready_o, cmpl_valid_o);
      end
      tick();
      if (job_ready_o !== 1'b0 || cmpl_valid_o !== 1'b0) begin
         err_cnt++; $display("FAIL fpp_pop_cycle ready=%b valid=%b required 0/0", job_ready_o, cmpl_valid_o);
      end
      tick();
      job_valid_i = 1'b0;
      chk_cnt++;
      if (job_ready_o !== 1'b1) begin
         err_cnt++; $display("FAIL fpp_occupancy ready=%b required 1 after 4->3", job_ready_o);
      end
      wait_drain();
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      repeat (4) begin
         tick();
         if (cmpl_valid_o || busy_o || ctrl_start_o) idle_bad++;
      end
      chk_cnt++;
      if (idle_bad !== 0) begin
         err_cnt++; $display("FAIL spurious_done reacted in %0d cycles required 0", idle_bad);
      end
   endtask

   task automatic test_zero_size();
      int starts = 0;
      done_lat = 10; auto_done = 1'b1;
      offer(16'd3, 16'd0, 16'd5, 4'd7);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ctrl_start_o) starts++;
         if (i == 0) begin
            chk_cnt += 2;
            if (cmpl_valid_o !== 1'b1) begin
               err_cnt++; $display("FAIL zero_report valid=%b required 1", cmpl_valid_o);
            end
            if ({ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o} !== {16'd3, 16'd0, 16'd5}) begin
               err_cnt++;
               $display("FAIL zero_sizes got %0d/%0d/%0d required 3/0/5", ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o);
            end
         end
      end
      chk_cnt++;
      if (starts !== 0) begin
         err_cnt++; $display("FAIL zero_start got %0d starts required 0", starts);
      end
      wait_drain();
   endtask

   task automatic test_ready_stall();
      int          w = 0;
      logic [36:0] held;
      done_lat = 2; auto_done = 1'b1; cmpl_ready_i = 1'b0;
      offer(16'd5, 16'd6, 16'd7, 4'd1);
      offer(16'd8, 16'd9, 16'd10, 4'd2);
      while (!cmpl_valid_o && w < 40) begin
         tick();
         w++;
      end
      held = {cmpl_id_o, cmpl_err_o, cmpl_cycles_o};
      chk_cnt++;
      if (w >= 40) begin
         err_cnt++; $display("FAIL stall_wait_valid valid=%b required 1", cmpl_valid_o);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_cnt += 2;
         if (cmpl_valid_o !== 1'b1 || {cmpl_id_o, cmpl_err_o, cmpl_cycles_o} !== held) begin
            err_cnt++;
            $display("FAIL stall_hold cyc%0d valid=%b id=%0d cyc=%0d required 1/%0d/%0d",
                     i, cmpl_valid_o, cmpl_id_o, cmpl_cycles_o, held[36:33], held[31:0]);
         end
         if (ctrl_start_o !== 1'b0) begin
            err_cnt++; $display("FAIL stall_start cyc%0d start=%b required 0", i, ctrl_start_o);
         end
      end
      cmpl_ready_i = 1'b1;
      tick();
      chk_cnt += 2;
      if (ctrl_start_o !== 1'b0) begin
         err_cnt++; $display("FAIL stall_release_early start=%b required 0", ctrl_start_o);
      end
      tick();
      if (ctrl_start_o !== 1'b1 || ctrl_m_size_o !== 16'd8) begin
         err_cnt++; $display("FAIL stall_next_start start=%b m=%0d required 1/8", ctrl_start_o, ctrl_m_size_o);
      end
      wait_drain();
   endtask

   task automatic test_reset_mid_job();
      int bad = 0;
      auto_done = 1'b0;
      offer(16'd4, 16'd4, 16'd4, 4'd10);
      offer(16'd1, 16'd2, 16'd3, 4'd11);
      offer(16'd1, 16'd2, 16'd3, 4'd12);
      rst_ni = 1'b0;
      tick();
      chk_cnt += 3;
      if ({ctrl_start_o, cmpl_valid_o, busy_o, job_ready_o} !== 4'b0001) begin
         err_cnt++;
         $display("FAIL midrst_ctrl start/valid/busy/ready=%b required 0001",
                  {ctrl_start_o, cmpl_valid_o, busy_o, job_ready_o});
      end
      if ({ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o} !== 48'd0) begin
         err_cnt++;
         $display("FAIL midrst_sizes got %0d/%0d/%0d required 0", ctrl_m_size_o, ctrl_k_size_o, ctrl_n_size_o);
      end
      if ({cmpl_id_o, cmpl_err_o, cmpl_cycles_o} !== 37'd0) begin
         err_cnt++;
         $display("FAIL midrst_cmpl id=%0d err=%b cyc=%0d required 0", cmpl_id_o, cmpl_err_o, cmpl_cycles_o);
      end
      rst_ni = 1'b1;
      exp_q.delete();
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      repeat (8) begin
         tick();
         if (cmpl_valid_o || ctrl_start_o || busy_o) bad++;
      end
      chk_cnt++;
      if (bad !== 0) begin
         err_cnt++; $display("FAIL midrst_after activity in %0d cycles required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full_push_pop();
      test_zero_size();
      test_ready_stall();
      test_reset_mid_job();
      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout after %0d cycles", cyc_cnt);
      $fatal(1);
   end

endmodule
